// File: rtl/wb_master_engine.sv
// wb_master_engine: Wishbone classic initiator that turns one accepted command
// into single or incrementing-burst 32-bit transfers, fed by a write-data stream
// and draining into a read-data stream. It reports completion with a done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | ready for a command; cmd_ready high
// S_WDATA | waiting for the next write beat on the wdata stream
// S_BUS   | stb/cyc asserted, waiting for ack, err or timeout
// S_RESP  | read beat held on rdata until the consumer takes it
// S_DONE  | one-cycle completion; done pulses with done_err
module wb_master_engine #(
    parameter int unsigned ADDR_INC       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned LEN_W          = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,

    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,

    output logic             done,
    output logic             done_err,
    output logic             busy,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_BUS   = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // The timeout counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned     TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     ADR_STEP = 32'(ADDR_INC);

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_o_q, dat_o_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              done_q, done_d;
    logic              done_err_q, done_err_d;
    logic              busy_q, busy_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic [LEN_W-1:0]  beat_inc;
    logic              last_beat;
    logic              to_expire;

    assign beat_inc  = beat_q + LEN_W'(1);
    assign last_beat = (beat_inc == len_q);
    assign to_expire = (TIMEOUT_CYCLES != 0) && (to_q == TO_LAST);

    // Handshake readies are decoded straight from state; both stay low in reset.
    assign cmd_ready   = (state_q == S_IDLE)  && !wb_rst_i;
    assign wdata_ready = (state_q == S_WDATA) && !wb_rst_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        adr_d         = adr_q;
        dat_o_d       = dat_o_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        done_err_d    = done_err_q;
        len_d         = len_q;
        beat_d        = beat_q;
        to_d          = to_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d   = cmd_we;
                    len_d  = cmd_len;
                    beat_d = '0;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        adr_d = cmd_addr & 32'hFFFF_FFFC;
                        if (cmd_we) begin
                            state_d = S_WDATA;
                        end else begin
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            to_d    = '0;
                            state_d = S_BUS;
                        end
                    end
                end
            end

            S_WDATA: begin
                if (wdata_valid) begin
                    dat_o_d = wdata;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    to_d    = '0;
                    state_d = S_BUS;
                end
            end

            S_BUS: begin
                if (wbm_err_i) begin
                    // err outranks a simultaneous ack; the beat is thrown away.
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_err_d = 1'b1;
                    state_d    = S_DONE;
                end else if (wbm_ack_i) begin
                    stb_d = 1'b0;
                    if (!we_q) begin
                        rdata_d       = wbm_dat_i;
                        rdata_valid_d = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        beat_d = beat_inc;
                        adr_d  = adr_q + ADR_STEP;
                        if (last_beat) begin
                            cyc_d   = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end else if (to_expire) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    done_err_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_RESP: begin
                if (rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    beat_d        = beat_inc;
                    adr_d         = adr_q + ADR_STEP;
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        stb_d   = 1'b1;
                        to_d    = '0;
                        state_d = S_BUS;
                    end
                end
            end

            S_DONE: begin
                done_err_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
        sel_d  = stb_d ? 4'hF : 4'h0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= S_IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            sel_q         <= 4'h0;
            adr_q         <= 32'h0;
            dat_o_q       <= 32'h0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            len_q         <= '0;
            beat_q        <= '0;
            to_q          <= '0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            adr_q         <= adr_d;
            dat_o_q       <= dat_o_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            done_err_q    <= done_err_d;
            busy_q        <= busy_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            to_q          <= to_d;
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_o_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign done_err    = done_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// Testbench for wb_master_engine: behavioural Wishbone slave, stream drivers,
// a table of directed commands, hand-written corner sequences and random commands.
module tb_wb_master_engine;

    localparam int TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        done, done_err, busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_master_engine #(.ADDR_INC(4), .TIMEOUT_CYCLES(TO), .LEN_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .done_err(done_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    int checks = 0;
    int errors = 0;

    // slave behaviour
    int  slv_wait, slv_err_beat, slv_wcnt, slv_beat;
    bit  slv_ackerr, slv_never;
    // stream behaviour: 0 = low, 1 = high, 2 = random
    int  wv_mode = 2, rr_mode = 2;
    int  stall_beat = -1, stall_len = 0, stall_cnt = 0;

    logic [31:0] rd_src[$];
    logic [31:0] rd_ret[$];
    logic [31:0] tx_adr[$];
    logic        tx_we[$];
    logic [31:0] tx_dat[$];
    logic [31:0] wsrc[$];
    logic [31:0] wgot[$];
    logic [31:0] rgot[$];
    int          stb_ticks[$];
    int          rv_ticks[$];
    int          widx;

    int  tick_n = 0, acc_tick = 0, done_tick = 0;
    int  done_cnt, stb_cycles, stb_rise, cyc_rise;
    bit  done_err_seen;
    bit  prev_stb = 0, prev_cyc = 0, prev_rv = 0, prev_rv_stall = 0;
    logic [31:0] prev_rdata = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One clock cycle: sample DUT outputs at the falling edge, then drive
    // the slave response and stream inputs for the coming rising edge.
    task automatic tick();
        bit          wv, rr;
        logic [31:0] d;
        @(negedge wb_clk_i);
        tick_n++;

        if (done) begin
            done_cnt++;
            done_err_seen = done_err;
            done_tick     = tick_n;
            check("cyc_low_at_done", 32'(wbm_cyc_o), 32'd0);
        end
        if (wbm_stb_o) begin
            stb_cycles++;
            check("sel_during_stb", 32'(wbm_sel_o), 32'hF);
            check("cyc_during_stb", 32'(wbm_cyc_o), 32'd1);
            if (!prev_stb) begin
                stb_rise++;
                stb_ticks.push_back(tick_n);
            end
        end
        if (wbm_cyc_o && !prev_cyc) cyc_rise++;
        if (rdata_valid && !prev_rv) rv_ticks.push_back(tick_n);
        if (rdata_valid && prev_rv_stall) check("rdata_held", rdata, prev_rdata);
        prev_stb = wbm_stb_o;
        prev_cyc = wbm_cyc_o;
        prev_rv  = rdata_valid;

        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
        if (wbm_stb_o && !slv_never) begin
            if (slv_wcnt == slv_wait) begin
                tx_adr.push_back(wbm_adr_o);
                tx_we.push_back(wbm_we_o);
                tx_dat.push_back(wbm_dat_o);
                if (slv_beat == slv_err_beat) begin
                    wbm_err_i = 1'b1;
                    wbm_ack_i = slv_ackerr;
                end else begin
                    wbm_ack_i = 1'b1;
                end
                if (!wbm_we_o) begin
                    d = (rd_src.size() > 0) ? rd_src.pop_front() : $urandom;
                    wbm_dat_i = d;
                    if (!wbm_err_i) rd_ret.push_back(d);
                end
                slv_beat++;
                slv_wcnt = 0;
            end else begin
                slv_wcnt++;
            end
        end else if (!wbm_stb_o) begin
            slv_wcnt = 0;
        end

        case (wv_mode)
            0:       wv = 1'b0;
            1:       wv = 1'b1;
            default: wv = 1'($urandom_range(0, 1));
        endcase
        wdata_valid = wv && (widx < wsrc.size());
        wdata       = wdata_valid ? wsrc[widx] : $urandom;
        if (wdata_valid && wdata_ready) begin
            wgot.push_back(wdata);
            widx++;
        end

        case (rr_mode)
            0:       rr = 1'b0;
            1:       rr = 1'b1;
            default: rr = 1'($urandom_range(0, 1));
        endcase
        if (rdata_valid && stall_beat >= 0 && rgot.size() == stall_beat && stall_cnt < stall_len) begin
            rr = 1'b0;
            stall_cnt++;
        end
        rdata_ready   = rr;
        prev_rv_stall = rdata_valid && !rr;
        prev_rdata    = rdata;
        if (rdata_valid && rr) rgot.push_back(rdata);
    endtask

    task automatic prep(input int waitc, input int err_beat, input bit ackerr, input bit never);
        slv_wait = waitc; slv_err_beat = err_beat; slv_ackerr = ackerr; slv_never = never;
        slv_wcnt = 0; slv_beat = 0; widx = 0; stall_cnt = 0;
        tx_adr.delete(); tx_we.delete(); tx_dat.delete(); rd_ret.delete();
        wgot.delete(); rgot.delete(); stb_ticks.delete(); rv_ticks.delete();
        done_cnt = 0; stb_cycles = 0; stb_rise = 0; cyc_rise = 0; done_err_seen = 0;
    endtask

    task automatic issue(input bit we, input logic [31:0] addr, input int len);
        int n = 0;
        tick();
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        acc_tick  = tick_n;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_len   = 8'($urandom);
    endtask

    // Runs one command and compares against the rules: beat i sits at
    // (addr & ~3) + 4*i, an error or timeout on beat k ends the command after
    // k+1 bus attempts, reads deliver every successfully acked beat in order.
    task automatic run_cmd(input bit we, input logic [31:0] addr, input int len, input int waitc,
                           input int err_beat, input bit ackerr, input bit never, input string tag);
        int          budget = 0;
        int          attempted, exp_tx, exp_stb, exp_rd;
        bit          exp_err;
        logic [31:0] base;
        prep(waitc, err_beat, ackerr, never);
        while (wsrc.size() < len) wsrc.push_back($urandom);
        issue(we, addr, len);
        while (done_cnt == 0 && budget < 400) begin
            tick();
            budget++;
        end
        tick();
        tick();

        base = addr & 32'hFFFF_FFFC;
        if (len == 0)                                   attempted = 0;
        else if (never)                                 attempted = 1;
        else if (err_beat >= 0 && err_beat < len)       attempted = err_beat + 1;
        else                                            attempted = len;
        exp_err = (len != 0) && (never || (err_beat >= 0 && err_beat < len));
        exp_tx  = never ? 0 : attempted;
        exp_stb = attempted;
        exp_rd  = we ? 0 : (exp_err ? attempted - 1 : attempted);

        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " done_err"}, 32'(done_err_seen), 32'(exp_err));
        check({tag, " stb_attempts"}, 32'(stb_rise), 32'(exp_stb));
        check({tag, " cyc_rises"}, 32'(cyc_rise), (len > 0) ? 32'd1 : 32'd0);
        check({tag, " bus_terminations"}, 32'(tx_adr.size()), 32'(exp_tx));
        for (int i = 0; i < tx_adr.size() && i < exp_tx; i++) begin
            check($sformatf("%s adr%0d", tag, i), tx_adr[i], base + 32'(4 * i));
            check($sformatf("%s we%0d", tag, i), 32'(tx_we[i]), 32'(we));
            if (we) check($sformatf("%s wdat%0d", tag, i), tx_dat[i], wsrc[i]);
        end
        check({tag, " wdata_consumed"}, 32'(wgot.size()), we ? 32'(attempted) : 32'd0);
        check({tag, " rdata_beats"}, 32'(rgot.size()), 32'(exp_rd));
        for (int i = 0; i < rgot.size() && i < rd_ret.size(); i++)
            check($sformatf("%s rdata%0d", tag, i), rgot[i], rd_ret[i]);
        if (never && len > 0) check({tag, " timeout_stb_cycles"}, 32'(stb_cycles), 32'(TO));
        check({tag, " idle_cyc"}, 32'(wbm_cyc_o), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_rvalid"}, 32'(rdata_valid), 32'd0);
        check({tag, " idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
        wsrc.delete();
        rd_src.delete();
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          len;
        int          waitc;
        int          err_beat;
        bit          ackerr;
        bit          never;
        int          exp_stb;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        prep(0, -1, 0, 0);

        vecs.push_back('{1'b1, 32'h0000_2000, 3, 1, 1, 1'b0, 1'b0, 2, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_4000, 1, 0, -1, 1'b0, 1'b1, 1, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_5000, 0, 0, -1, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_5004, 0, 0, -1, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 2, 0, -1, 1'b0, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_6000, 2, 0, 0, 1'b1, 1'b0, 1, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_7000, 2, 2, 1, 1'b1, 1'b0, 2, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_1003, 2, 3, -1, 1'b0, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_8000, 5, 1, 3, 1'b0, 1'b0, 4, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_9000, 1, 0, -1, 1'b0, 1'b1, 1, 1'b1});

        // reset state
        tick();
        tick();
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst stb", 32'(wbm_stb_o), 32'd0);
        check("rst adr", wbm_adr_o, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        wb_rst_i = 1'b0;
        tick();
        check("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

        // single write with two wait states
        wsrc.push_back(32'hDEAD_BEEF);
        run_cmd(1'b1, 32'h3000_0000, 1, 2, -1, 1'b0, 1'b0, "single_wr");
        check("single_wr stb_cycles", 32'(stb_cycles), 32'd3);
        if (tx_adr.size() > 0) begin
            check("single_wr adr", tx_adr[0], 32'h3000_0000);
            check("single_wr dat", tx_dat[0], 32'hDEAD_BEEF);
        end

        // read burst with the consumer stalling on the second beat
        rd_src.push_back(32'h11); rd_src.push_back(32'h22);
        rd_src.push_back(32'h33); rd_src.push_back(32'h44);
        stall_beat = 1; stall_len = 3; rr_mode = 1;
        run_cmd(1'b0, 32'h3000_0010, 4, 0, -1, 1'b0, 1'b0, "rd_burst");
        check("rd_burst stall_cycles", 32'(stall_cnt), 32'd3);
        if (rgot.size() == 4) begin
            check("rd_burst d0", rgot[0], 32'h11);
            check("rd_burst d1", rgot[1], 32'h22);
            check("rd_burst d2", rgot[2], 32'h33);
            check("rd_burst d3", rgot[3], 32'h44);
        end
        if (tx_adr.size() == 4) check("rd_burst last_adr", tx_adr[3], 32'h3000_001C);
        stall_beat = -1; stall_len = 0;

        // read latency with zero-wait slave and consumer always ready
        run_cmd(1'b0, 32'h0000_0100, 2, 0, -1, 1'b0, 1'b0, "rd_lat");
        if (stb_ticks.size() == 2 && rv_ticks.size() == 2) begin
            check("rd_lat first_stb", 32'(stb_ticks[0] - acc_tick), 32'd1);
            check("rd_lat first_rvalid", 32'(rv_ticks[0] - acc_tick), 32'd2);
            check("rd_lat second_stb", 32'(stb_ticks[1] - acc_tick), 32'd3);
            check("rd_lat done_after_hs", 32'(done_tick - rv_ticks[1]), 32'd1);
        end else begin
            check("rd_lat stb_edges", 32'(stb_ticks.size()), 32'd2);
        end
        rr_mode = 2;

        // write throughput with write data always offered
        wv_mode = 1;
        run_cmd(1'b1, 32'h0000_0200, 3, 0, -1, 1'b0, 1'b0, "wr_lat");
        if (stb_ticks.size() == 3) begin
            check("wr_lat first_stb", 32'(stb_ticks[0] - acc_tick), 32'd2);
            check("wr_lat beat_spacing1", 32'(stb_ticks[1] - stb_ticks[0]), 32'd2);
            check("wr_lat beat_spacing2", 32'(stb_ticks[2] - stb_ticks[1]), 32'd2);
        end else begin
            check("wr_lat stb_edges", 32'(stb_ticks.size()), 32'd3);
        end
        wv_mode = 2;

        // table of directed commands
        foreach (vecs[k]) begin
            run_cmd(vecs[k].we, vecs[k].addr, vecs[k].len, vecs[k].waitc, vecs[k].err_beat,
                    vecs[k].ackerr, vecs[k].never, $sformatf("vec%0d", k));
            check($sformatf("vec%0d tbl_stb", k), 32'(stb_rise), 32'(vecs[k].exp_stb));
            check($sformatf("vec%0d tbl_err", k), 32'(done_err_seen), 32'(vecs[k].exp_err));
            if (vecs[k].len == 0)
                check($sformatf("vec%0d len0_latency", k), (done_tick - acc_tick <= 2) ? 32'd1 : 32'd0, 32'd1);
            if (vecs[k].addr == 32'hFFFF_FFFC && tx_adr.size() == 2)
                check("wrap second_adr", tx_adr[1], 32'h0000_0000);
        end

        // reset while a read beat is held waiting for the consumer
        rr_mode = 0;
        prep(0, -1, 0, 0);
        issue(1'b0, 32'h0000_A000, 4);
        for (int n = 0; n < 20 && !rdata_valid; n++) tick();
        check("mid_rst rvalid_before", 32'(rdata_valid), 32'd1);
        wb_rst_i = 1'b1;
        done_cnt = 0;
        tick();
        check("mid_rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst wdata_ready", 32'(wdata_ready), 32'd0);
        check("mid_rst outs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rdata_valid, done, done_err, busy, wbm_sel_o},
              32'd0);
        check("mid_rst adr", wbm_adr_o, 32'd0);
        check("mid_rst dat_o", wbm_dat_o, 32'd0);
        check("mid_rst rdata", rdata, 32'd0);
        wb_rst_i = 1'b0;
        tick();
        check("mid_rst cmd_ready_after", 32'(cmd_ready), 32'd1);
        tick();
        check("mid_rst no_done", 32'(done_cnt), 32'd0);
        rr_mode = 2;
        run_cmd(1'b0, 32'h0000_B000, 2, 1, -1, 1'b0, 1'b0, "after_rst");

        // random commands against the rule model
        for (int r = 0; r < 40; r++) begin
            bit          we, ackerr, never;
            logic [31:0] addr;
            int          len, waitc, eb;
            we     = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            len    = $urandom_range(0, 6);
            waitc  = $urandom_range(0, 3);
            eb     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            ackerr = 1'($urandom_range(0, 1));
            never  = ($urandom_range(0, 9) == 0);
            run_cmd(we, addr, len, waitc, eb, ackerr, never, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_master_engine.md
Name: wb_master_engine

Overview:
- Wishbone classic initiator that issues single or incremental-burst 32-bit read/write transfers on behalf of a command/stream interface.
- Drives the same Wishbone slave port that the accelerator top exposes.
- Used as the on-chip/testbench-side initiator for register and buffer access to the accelerator.
- Also serves as a reusable master for internal DMA-style moves.

Parameters:
- ADDR_INC, 4: byte address increment per beat.
- TIMEOUT_CYCLES, 255: max cycles stb may wait for ack/err before abort; 0 disables timeout.
- LEN_W, 8: width of burst length field.

Ports:
- wb_clk_i  input  1  single clock.
- wb_rst_i  input  1  synchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  engine idle, command accepted when valid&ready.
- cmd_we  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  32  start byte address; bits[1:0] ignored (forced 0).
- cmd_len  input  LEN_W  beat count; 0 = no-op.
- wdata_valid  input  1  write data offered.
- wdata_ready  output  1  write data accepted when valid&ready.
- wdata  input  32  write beat data.
- rdata_valid  output  1  read beat available.
- rdata_ready  input  1  consumer takes read beat.
- rdata  output  32  read beat data.
- done  output  1  one-cycle pulse at command completion.
- done_err  output  1  valid with done: 1 = aborted by err/timeout.
- busy  output  1  high whenever not IDLE.
- wbm_cyc_o  output  1  bus cycle.
- wbm_stb_o  output  1  strobe.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  4  byte selects, always 4'hF during stb.
- wbm_adr_o  output  32  address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  slave ack.
- wbm_err_i  input  1  slave error.

Behaviour:
- All outputs registered except cmd_ready, wdata_ready (decoded from state).
- Reset (synchronous, any state, including mid-burst): state IDLE; cyc/stb/we/done/done_err/rdata_valid/busy = 0; adr/dat_o/sel/rdata = 0; beat counter and timeout counter = 0. cmd_ready = 0 while wb_rst_i high.
- States: IDLE, WDATA, BUS, RESP, DONE.
- IDLE: cmd_ready = 1. On accept, latch we, addr&~3, len; beat counter = 0.
  - len == 0 → DONE (no bus activity).
  - len > 0, write → WDATA.
  - len > 0, read → BUS: stb/cyc high the cycle after accept.
- WDATA: wdata_ready = 1. On wdata_valid, latch wdata into wbm_dat_o → BUS (stb high next cycle).
- BUS:
  - stb = 1, cyc = 1, we = latched we, sel = F.
  - adr/dat_o stable until termination.
  - Terminated by ack or err at a clock edge. stb drops on that same edge, so each ack is consumed exactly once.
  - Read ack: rdata <= wbm_dat_i, rdata_valid <= 1 → RESP.
  - Write ack: beat counter +1, adr += ADDR_INC. Last beat → DONE, else → WDATA.
  - cyc stays high between beats of a burst, with stb low.
- RESP: hold rdata_valid/rdata until rdata_ready. On handshake, beat counter +1, adr += ADDR_INC. Last beat → DONE, else → BUS.
- Abort:
  - Triggers: err_i during BUS, or timeout counter reaching TIMEOUT_CYCLES-1 while stb high without ack/err.
  - cyc/stb drop on that edge, done_err latched 1 → DONE.
  - Remaining beats discarded; no further wdata consumed; no rdata_valid for the aborted beat.
- ack and err in the same cycle: err wins, beat data discarded.
- Timeout counter clears on every stb assertion edge.
- DONE:
  - cyc = 0.
  - done = 1 for exactly one cycle, done_err as latched.
  - → IDLE, where done_err clears.
- Address arithmetic is mod 2^32: 0xFFFFFFFC + 4 → 0x00000000, no error.
- Latency, read with zero-wait slave (ack same cycle as stb):
  - Accept at edge 0; stb visible cycle 1; rdata_valid cycle 2.
  - With rdata_ready held, next stb cycle 3.
  - done asserts 1 cycle after the final rdata handshake.
- Latency, write with wdata always valid: one beat per 2 cycles after the initial WDATA cycle.

Test Plan:
- Single write: cmd(we=1, addr=0x3000_0000, len=1), wdata=0xDEADBEEF, slave acks after 2 wait cycles → one stb with adr=0x30000000, dat_o=0xDEADBEEF, sel=F for 3 cycles; done=1, done_err=0; cyc low after.
- Read burst: cmd(we=0, addr=0x3000_0010, len=4), slave returns 0x11,0x22,0x33,0x44, rdata_ready stalled 3 cycles on beat 2 → adr sequence 0x10, 0x14, 0x18, 0x1C; rdata in order; rdata held during stall; cyc high throughout; exactly one done pulse.
- Error abort: write len=3, slave asserts err on beat 2 → cyc/stb drop that edge; done=1, done_err=1; exactly 2 wdata beats consumed; third never requested; next command accepted normally.
- Timeout: TIMEOUT_CYCLES=8, read len=1, slave never acks → stb high exactly 8 cycles; then done_err=1; no rdata_valid.
- Edge cases: len=0 → done within 2 cycles, cyc never asserted. Addr 0xFFFFFFFC, len=2 → second adr=0x00000000. ack+err same cycle → done_err=1.
- Reset mid-burst during RESP with rdata_valid=1 → next cycle all outputs at reset values; no done pulse; cmd_ready=1 after wb_rst_i falls.
